// File: rtl/pong_pkg.sv
// Shared definitions for the pong game-flow controller.
//   state_e      : game phase encoding, also exported on game_state
//   BCD_W        : width of one BCD digit
//   REFRESH_LINE : scan line on which the frame refresh tick fires
//   bcd_to_bin   : 2-digit BCD to binary (0..99) conversion
package pong_pkg;

    typedef enum logic [1:0] {
        ST_NEWGAME = 2'b00,
        ST_PLAY    = 2'b01,
        ST_NEWBALL = 2'b10,
        ST_OVER    = 2'b11
    } state_e;

    localparam int BCD_W        = 4;
    localparam int REFRESH_LINE = 481;

    function automatic logic [6:0] bcd_to_bin(input logic [7:0] bcd);
        bcd_to_bin = ({3'b000, bcd[7:4]} * 7'd10) + {3'b000, bcd[3:0]};
    endfunction

endpackage

// File: rtl/pong_score_bcd.sv
// Two-digit saturating BCD score counter.
//   clk     : system clock
//   reset_n : synchronous active-low reset, clears the count
//   clr     : synchronous clear (wins over inc)
//   inc     : add one; 99 holds at 99
//   bcd     : registered count {tens, units}
//   bin     : the same count in binary, 0..99
module pong_score_bcd
    import pong_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clr,
    input  logic       inc,
    output logic [7:0] bcd,
    output logic [6:0] bin
);

    logic [BCD_W-1:0] units_q, units_d;
    logic [BCD_W-1:0] tens_q, tens_d;

    always_comb begin
        units_d = units_q;
        tens_d  = tens_q;
        if (clr) begin
            units_d = '0;
            tens_d  = '0;
        end else if (inc) begin
            if (units_q == 4'd9) begin
                // At 99 both digits stay put; otherwise carry into tens.
                if (tens_q != 4'd9) begin
                    units_d = '0;
                    tens_d  = tens_q + 4'd1;
                end
            end else begin
                units_d = units_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            units_q <= '0;
            tens_q  <= '0;
        end else begin
            units_q <= units_d;
            tens_q  <= tens_d;
        end
    end

    assign bcd = {tens_q, units_q};
    assign bin = bcd_to_bin(bcd);

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game-flow controller: scoring, serve pauses and game-over sequencing
// downstream of the graphics stage.
//   clk, reset_n   : clock, synchronous active-low reset
//   refresh_tick   : one-clk pulse per frame; paces the pause timers
//   pts_1, pts_2   : point levels from graphics (player 1 / player 2 scores)
//   btn_start      : debounced start button level
//   gra_still      : 1 = graphics holds the ball at centre (any phase but PLAY)
//   score1, score2 : BCD scores {tens, units}
//   game_state     : current phase (state_e encoding)
//   winner         : 0 = player 1, 1 = player 2; meaningful in OVER
//   game_over      : 1 while in OVER
// Every output is a flop or a decode of the state flop.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE     = 5,
    parameter int NEWBALL_TICKS = 120,
    parameter int OVER_TICKS    = 180,
    parameter int TIMER_W       = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       refresh_tick,
    input  logic       pts_1,
    input  logic       pts_2,
    input  logic       btn_start,
    output logic       gra_still,
    output logic [7:0] score1,
    output logic [7:0] score2,
    output logic [1:0] game_state,
    output logic       winner,
    output logic       game_over
);

    localparam logic [TIMER_W-1:0] NEWBALL_LOAD = TIMER_W'(NEWBALL_TICKS - 1);
    localparam logic [TIMER_W-1:0] OVER_LOAD    = TIMER_W'(OVER_TICKS - 1);
    localparam logic [6:0]         WIN_BIN      = 7'(WIN_SCORE);

    state_e               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic                 winner_q, winner_d;
    logic                 btn_start_q, btn_start_d;
    logic                 start_armed_q, start_armed_d;

    logic                 start_rise;
    logic                 clr_scores;
    logic                 inc1, inc2;
    logic [6:0]           s1_bin, s2_bin;
    logic [6:0]           s1_next_bin, s2_next_bin;

    // The edge register alone would see a start held through reset as a
    // fresh press; start_armed_q only sets once the button has been seen
    // released, so a held start needs a release and re-press.
    assign btn_start_d   = btn_start;
    assign start_armed_d = ~btn_start;
    assign start_rise    = btn_start & ~btn_start_q & start_armed_q;

    // Value each score would take if incremented now (saturating at 99),
    // used to decide between NEWBALL and OVER on the scoring edge.
    assign s1_next_bin = (s1_bin == 7'd99) ? 7'd99 : s1_bin + 7'd1;
    assign s2_next_bin = (s2_bin == 7'd99) ? 7'd99 : s2_bin + 7'd1;

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        winner_d   = winner_q;
        clr_scores = 1'b0;
        inc1       = 1'b0;
        inc2       = 1'b0;

        case (state_q)
            ST_NEWGAME: begin
                // Held at zero here, which also covers clearing on exit.
                clr_scores = 1'b1;
                if (start_rise) begin
                    state_d = ST_PLAY;
                end
            end

            ST_PLAY: begin
                // pts_1 wins a tie; the other point is dropped because
                // leaving PLAY recentres the ball.
                if (pts_1) begin
                    inc1 = 1'b1;
                    if (s1_next_bin == WIN_BIN) begin
                        state_d  = ST_OVER;
                        winner_d = 1'b0;
                        timer_d  = OVER_LOAD;
                    end else begin
                        state_d  = ST_NEWBALL;
                        timer_d  = NEWBALL_LOAD;
                    end
                end else if (pts_2) begin
                    inc2 = 1'b1;
                    if (s2_next_bin == WIN_BIN) begin
                        state_d  = ST_OVER;
                        winner_d = 1'b1;
                        timer_d  = OVER_LOAD;
                    end else begin
                        state_d  = ST_NEWBALL;
                        timer_d  = NEWBALL_LOAD;
                    end
                end
            end

            ST_NEWBALL: begin
                if (refresh_tick) begin
                    if (timer_q == '0) begin
                        state_d = ST_PLAY;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
            end

            ST_OVER: begin
                if (refresh_tick) begin
                    if (timer_q == '0) begin
                        state_d    = ST_NEWGAME;
                        clr_scores = 1'b1;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_NEWGAME;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_NEWGAME;
            timer_q       <= '0;
            winner_q      <= 1'b0;
            btn_start_q   <= 1'b0;
            start_armed_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            winner_q      <= winner_d;
            btn_start_q   <= btn_start_d;
            start_armed_q <= start_armed_d;
        end
    end

    pong_score_bcd u_score1 (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clr_scores),
        .inc     (inc1),
        .bcd     (score1),
        .bin     (s1_bin)
    );

    pong_score_bcd u_score2 (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clr_scores),
        .inc     (inc2),
        .bcd     (score2),
        .bin     (s2_bin)
    );

    assign game_state = state_q;
    assign gra_still  = (state_q != ST_PLAY);
    assign game_over  = (state_q == ST_OVER);
    assign winner     = winner_q;

endmodule
